// File: rtl/instr_decode.sv
// Decode stage: IF/ID register, 32-entry register file with write-through bypass,
// control decode and the ID/EX pipeline register feeding execute.
module instr_decode #(
   parameter int          DATA_W    = 32,
   parameter int          REG_AW    = 5,
   parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       pc_next_in,
   input  logic [31:0]       instruction_in,
   input  logic              stall,
   input  logic              flush,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_write_reg,
   input  logic [DATA_W-1:0] wb_write_data,
   output logic [31:0]       pc_next_out,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   output logic [DATA_W-1:0] imm_ext,
   output logic [REG_AW-1:0] rs_out,
   output logic [REG_AW-1:0] rt_out,
   output logic [REG_AW-1:0] rd_out,
   output logic              reg_dst,
   output logic              alu_src,
   output logic              mem_to_reg,
   output logic              reg_write,
   output logic              mem_read,
   output logic              mem_write,
   output logic              branch,
   output logic [1:0]        alu_op,
   output logic              illegal_op
);

   localparam int NREGS = 2 ** REG_AW;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   logic [31:0]       ifid_instr;
   logic [31:0]       ifid_pc;
   logic [DATA_W-1:0] regs [NREGS];

   logic [REG_AW-1:0] dec_rs, dec_rt, dec_rd;
   logic [DATA_W-1:0] dec_rd1, dec_rd2, dec_imm;
   logic              dec_reg_dst, dec_alu_src, dec_mem_to_reg, dec_reg_write;
   logic              dec_mem_read, dec_mem_write, dec_branch, dec_illegal;
   logic [1:0]        dec_alu_op;
   logic              wb_active;

   // IF/ID register: flush wins over stall
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ifid_instr <= NOP_INSTR;
         ifid_pc    <= '0;
      end else if (flush) begin
         ifid_instr <= NOP_INSTR;
         ifid_pc    <= '0;
      end else if (!stall) begin
         ifid_instr <= instruction_in;
         ifid_pc    <= pc_next_in;
      end
   end

   assign wb_active = wb_reg_write && (wb_write_reg != '0);

   // Register file; entry 0 is never written so it stays zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wb_active) begin
         regs[wb_write_reg] <= wb_write_data;
      end
   end

   assign dec_rs  = ifid_instr[25:21];
   assign dec_rt  = ifid_instr[20:16];
   assign dec_rd  = ifid_instr[15:11];
   assign dec_imm = {{(DATA_W-16){ifid_instr[15]}}, ifid_instr[15:0]};

   // Write-through bypass lets an instruction see a result retiring this cycle
   always_comb begin
      dec_rd1 = '0;
      dec_rd2 = '0;
      if (dec_rs != '0) dec_rd1 = (wb_active && wb_write_reg == dec_rs) ? wb_write_data : regs[dec_rs];
      if (dec_rt != '0) dec_rd2 = (wb_active && wb_write_reg == dec_rt) ? wb_write_data : regs[dec_rt];
   end

   always_comb begin
      dec_reg_dst    = 1'b0;
      dec_alu_src    = 1'b0;
      dec_mem_to_reg = 1'b0;
      dec_reg_write  = 1'b0;
      dec_mem_read   = 1'b0;
      dec_mem_write  = 1'b0;
      dec_branch     = 1'b0;
      dec_alu_op     = 2'b00;
      dec_illegal    = 1'b0;
      case (ifid_instr[31:26])
         OP_RTYPE: begin
            dec_reg_dst   = 1'b1;
            dec_reg_write = 1'b1;
            dec_alu_op    = 2'b10;
         end
         OP_LW: begin
            dec_alu_src    = 1'b1;
            dec_mem_to_reg = 1'b1;
            dec_reg_write  = 1'b1;
            dec_mem_read   = 1'b1;
         end
         OP_SW: begin
            dec_alu_src   = 1'b1;
            dec_mem_write = 1'b1;
         end
         OP_BEQ: begin
            dec_branch = 1'b1;
            dec_alu_op = 2'b01;
         end
         OP_ADDI: begin
            dec_alu_src   = 1'b1;
            dec_reg_write = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   // ID/EX register; stall or flush turns the controls into a bubble
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_next_out <= '0;
         read_data1  <= '0;
         read_data2  <= '0;
         imm_ext     <= '0;
         rs_out      <= '0;
         rt_out      <= '0;
         rd_out      <= '0;
         reg_dst     <= 1'b0;
         alu_src     <= 1'b0;
         mem_to_reg  <= 1'b0;
         reg_write   <= 1'b0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         branch      <= 1'b0;
         alu_op      <= 2'b00;
         illegal_op  <= 1'b0;
      end else begin
         pc_next_out <= ifid_pc;
         read_data1  <= dec_rd1;
         read_data2  <= dec_rd2;
         imm_ext     <= dec_imm;
         rs_out      <= dec_rs;
         rt_out      <= dec_rt;
         rd_out      <= dec_rd;
         if (stall || flush) begin
            reg_dst    <= 1'b0;
            alu_src    <= 1'b0;
            mem_to_reg <= 1'b0;
            reg_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            branch     <= 1'b0;
            alu_op     <= 2'b00;
            illegal_op <= 1'b0;
         end else begin
            reg_dst    <= dec_reg_dst;
            alu_src    <= dec_alu_src;
            mem_to_reg <= dec_mem_to_reg;
            reg_write  <= dec_reg_write;
            mem_read   <= dec_mem_read;
            mem_write  <= dec_mem_write;
            branch     <= dec_branch;
            alu_op     <= dec_alu_op;
            illegal_op <= dec_illegal;
         end
      end
   end

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: table of single-instruction vectors plus
// hand-written stall, flush and asynchronous reset sequences.
module tb_instr_decode;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_next_in, instruction_in;
   logic        stall, flush;
   logic        wb_reg_write;
   logic [4:0]  wb_write_reg;
   logic [31:0] wb_write_data;
   logic [31:0] pc_next_out, read_data1, read_data2, imm_ext;
   logic [4:0]  rs_out, rt_out, rd_out;
   logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
   logic [1:0]  alu_op;
   logic        illegal_op;

   int n_applied = 0;
   int n_miss    = 0;

   // ctrl packing: {reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,alu_op}
   localparam logic [8:0] C_R    = 9'b100100010;
   localparam logic [8:0] C_LW   = 9'b011110000;
   localparam logic [8:0] C_SW   = 9'b010001000;
   localparam logic [8:0] C_BEQ  = 9'b000000101;
   localparam logic [8:0] C_ADDI = 9'b010100000;
   localparam logic [8:0] C_NONE = 9'b000000000;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        wb_en;
      logic [4:0]  wb_reg;
      logic [31:0] wb_data;
      logic [31:0] e_rd1;
      logic [31:0] e_rd2;
      logic [31:0] e_imm;
      logic [4:0]  e_rs;
      logic [4:0]  e_rt;
      logic [4:0]  e_rd;
      logic [8:0]  e_ctrl;
      logic        e_ill;
   } vec_t;

   vec_t vecs[9];

   instr_decode dut (
      .clk(clk), .reset(reset),
      .pc_next_in(pc_next_in), .instruction_in(instruction_in),
      .stall(stall), .flush(flush),
      .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
      .pc_next_out(pc_next_out), .read_data1(read_data1), .read_data2(read_data2),
      .imm_ext(imm_ext), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
      .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
      .alu_op(alu_op), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] ctrl_now();
      return {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_idle();
      wb_reg_write  = 1'b0;
      wb_write_reg  = '0;
      wb_write_data = '0;
   endtask

   task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
      instruction_in = 32'h0;
      pc_next_in     = 32'h0;
      wb_reg_write   = 1'b1;
      wb_write_reg   = r;
      wb_write_data  = d;
      step();
      wb_idle();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".pc"},   pc_next_out, 32'h0);
      check({tag, ".rd1"},  read_data1, 32'h0);
      check({tag, ".rd2"},  read_data2, 32'h0);
      check({tag, ".imm"},  imm_ext, 32'h0);
      check({tag, ".regs"}, {17'h0, rs_out, rt_out, rd_out}, 32'h0);
      check({tag, ".ctrl"}, {23'h0, ctrl_now()}, 32'h0);
      check({tag, ".ill"},  {31'h0, illegal_op}, 32'h0);
   endtask

   // Capture into IF/ID, then advance to ID/EX with the write-back fields active
   task automatic apply(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      instruction_in = v.instr;
      pc_next_in     = v.pc;
      step();
      instruction_in = 32'h0;
      pc_next_in     = 32'h0;
      wb_reg_write   = v.wb_en;
      wb_write_reg   = v.wb_reg;
      wb_write_data  = v.wb_data;
      step();
      wb_idle();
      check({tag, ".pc"},   pc_next_out, v.pc);
      check({tag, ".rd1"},  read_data1, v.e_rd1);
      check({tag, ".rd2"},  read_data2, v.e_rd2);
      check({tag, ".imm"},  imm_ext, v.e_imm);
      check({tag, ".regs"}, {17'h0, rs_out, rt_out, rd_out}, {17'h0, v.e_rs, v.e_rt, v.e_rd});
      check({tag, ".ctrl"}, {23'h0, ctrl_now()}, {23'h0, v.e_ctrl});
      check({tag, ".ill"},  {31'h0, illegal_op}, {31'h0, v.e_ill});
   endtask

   initial begin
      //           instr         pc            wb wbreg wbdata        rd1           rd2           imm           rs  rt  rd  ctrl    ill
      vecs[0] = '{32'h012A4020, 32'h00000104, 0, 0,  32'h0,        32'h5,        32'h7,        32'h00004020, 9,  10, 8,  C_R,    0};
      vecs[1] = '{32'h8D28FFFC, 32'h00000108, 0, 0,  32'h0,        32'h5,        32'h0,        32'hFFFFFFFC, 9,  8,  31, C_LW,   0};
      vecs[2] = '{32'h212B0001, 32'h0000010C, 1, 9,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h00000001, 9,  11, 0,  C_ADDI, 0};
      vecs[3] = '{32'hAD2A0008, 32'h00000110, 0, 0,  32'h0,        32'hDEADBEEF, 32'h7,        32'h00000008, 9,  10, 0,  C_SW,   0};
      vecs[4] = '{32'h00001820, 32'h00000114, 1, 0,  32'h12345678, 32'h0,        32'h0,        32'h00001820, 0,  0,  3,  C_R,    0};
      vecs[5] = '{32'hFC000000, 32'h00000118, 0, 0,  32'h0,        32'h0,        32'h0,        32'h00000000, 0,  0,  0,  C_NONE, 1};
      vecs[6] = '{32'h112AFFFF, 32'h0000011C, 0, 0,  32'h0,        32'hDEADBEEF, 32'h7,        32'hFFFFFFFF, 9,  10, 31, C_BEQ,  0};
      vecs[7] = '{32'h014B6022, 32'h00000120, 1, 11, 32'hA5A5A5A5, 32'h7,        32'hA5A5A5A5, 32'h00006022, 10, 11, 12, C_R,    0};
      vecs[8] = '{32'h08000010, 32'h00000124, 0, 0,  32'h0,        32'h0,        32'h0,        32'h00000010, 0,  0,  0,  C_NONE, 1};

      reset = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      instruction_in = 32'h0;
      pc_next_in = 32'h0;
      wb_idle();
      #2;
      check_all_zero("reset");
      #10 reset = 1'b1;

      wb_write(5'd9, 32'd5);
      wb_write(5'd10, 32'd7);

      for (int i = 0; i < 9; i++) apply(vecs[i], i);

      // Stall with beq in IF/ID: bubble now, branch on the following edge
      instruction_in = 32'h112AFFFF;
      pc_next_in     = 32'h00000200;
      step();
      stall = 1'b1;
      instruction_in = 32'h8D28FFFC;
      pc_next_in     = 32'h00000204;
      step();
      stall = 1'b0;
      check("stall.ctrl", {23'h0, ctrl_now()}, {23'h0, C_NONE});
      check("stall.ill",  {31'h0, illegal_op}, 32'h0);
      instruction_in = 32'h0;
      pc_next_in     = 32'h0;
      step();
      check("stall.after.ctrl", {23'h0, ctrl_now()}, {23'h0, C_BEQ});
      check("stall.after.pc",   pc_next_out, 32'h00000200);
      check("stall.after.imm",  imm_ext, 32'hFFFFFFFF);

      // Stall and flush together: IF/ID becomes NOP
      instruction_in = 32'h8D28FFFC;
      pc_next_in     = 32'h00000300;
      step();
      stall = 1'b1;
      flush = 1'b1;
      instruction_in = 32'hFC000000;
      pc_next_in     = 32'h00000304;
      step();
      stall = 1'b0;
      flush = 1'b0;
      check("sflush.bubble.ctrl", {23'h0, ctrl_now()}, {23'h0, C_NONE});
      instruction_in = 32'h0;
      pc_next_in     = 32'h0;
      step();
      check("sflush.nop.ctrl", {23'h0, ctrl_now()}, {23'h0, C_R});
      check("sflush.nop.pc",   pc_next_out, 32'h0);
      check("sflush.nop.imm",  imm_ext, 32'h0);
      check("sflush.nop.ill",  {31'h0, illegal_op}, 32'h0);

      // Load a non-trivial ID/EX state, then reset between edges
      apply(vecs[6], 6);
      #2 reset = 1'b0;
      #1;
      check_all_zero("midreset");
      #2 reset = 1'b1;
      // Register file must be cleared: the add now reads zeros
      apply('{32'h012A4020, 32'h00000400, 0, 0, 32'h0, 32'h0, 32'h0, 32'h00004020, 9, 10, 8, C_R, 0}, 99);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
      $finish;
   end

endmodule

// File: doc/instr_decode.md
Name: instr_decode

Overview:
- Decode stage of the 5-stage pipelined MIPS-subset processor; sits directly downstream of the fetch stage.
- Consumes the fetch stage's instruction and pc_next outputs and holds them in an internal IF/ID register with stall/flush.
- Contains the 32x32 register file, with its write port driven from write-back.
- Decodes control, sign-extends the immediate and registers everything into the ID/EX pipeline register for the execute stage.

Parameters:
- DATA_W, 32, datapath and register width
- REG_AW, 5, register-file address width (2**REG_AW registers)
- NOP_INSTR, 32'h00000000, instruction word inserted on flush and at reset

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state
- pc_next_in  input  32  pc+4 from fetch
- instruction_in  input  32  fetched instruction
- stall  input  1  hold IF/ID and insert bubble into ID/EX (load-use)
- flush  input  1  squash IF/ID contents (taken branch)
- wb_reg_write  input  1  write-back enable
- wb_write_reg  input  5  write-back destination
- wb_write_data  input  32  write-back data
- pc_next_out  output  32  ID/EX pc+4
- read_data1  output  32  ID/EX rs value
- read_data2  output  32  ID/EX rt value
- imm_ext  output  32  ID/EX sign-extended instr[15:0]
- rs_out, rt_out, rd_out  output  5 each  ID/EX register fields
- reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch  output  1 each  ID/EX control
- alu_op  output  2  ID/EX ALU class: 00 add, 01 sub, 10 R-type funct, 11 unused
- illegal_op  output  1  ID/EX flag: unsupported opcode

Behaviour:
- Reset (reset=0, asynchronous):
  - IF/ID cleared: instr = NOP_INSTR, pc = 0.
  - All 32 registers = 0.
  - All ID/EX outputs = 0.
- IF/ID update, per rising edge:
  - flush=1 loads NOP_INSTR and pc 0.
  - Otherwise stall=1 holds the current contents.
  - Otherwise loads instruction_in and pc_next_in.
  - flush has priority over stall.
- Decode is combinational from IF/ID; rs = [25:21], rt = [20:16], rd = [15:11].
- Opcode table (reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op):
  - 0x00 R-type: 1,0,0,1,0,0,0,10
  - 0x23 lw: 0,1,1,1,1,0,0,00
  - 0x2B sw: 0,1,0,0,0,1,0,00
  - 0x04 beq: 0,0,0,0,0,0,1,01
  - 0x08 addi: 0,1,0,1,0,0,0,00
  - Any other opcode: all controls 0, illegal_op = 1.
- NOP_INSTR (all zero) decodes as R-type writing $0, which is architecturally harmless.
- Register file:
  - Written on the rising edge when wb_reg_write=1 and wb_write_reg != 0.
  - $0 always reads 0; writes to it are discarded.
  - Two combinational read ports.
  - Write-through bypass: if wb_reg_write=1, wb_write_reg != 0 and it equals rs (or rt), the read returns wb_write_data in the same cycle.
- ID/EX update, per rising edge:
  - If stall=1 or flush=1: all control outputs and illegal_op load 0 (bubble). Data fields load normally and are don't-care.
  - Otherwise loads all decoded values.
- Latency: instruction presented at fetch output in cycle n is captured into IF/ID at edge n and appears on ID/EX outputs after edge n+1.
- Immediate: imm_ext = {{16{instr[15]}}, instr[15:0]}.
- Reset asserted mid-operation: immediate clear of all state. The first instruction is captured on the first rising edge after deassertion.

Test Plan:
- Reset then R-type 0x012A4020 (add $8,$9,$10) with $9=5, $10=7 preloaded via WB -> two edges later read_data1=5, read_data2=7, rd_out=8, reg_dst=1, reg_write=1, alu_op=10.
- lw 0x8D28FFFC -> imm_ext=0xFFFFFFFC, alu_src=1, mem_read=1, mem_to_reg=1, rt_out=8.
- WB writes $9=0xDEADBEEF in the same cycle an instruction reading rs=$9 sits in IF/ID -> read_data1=0xDEADBEEF (bypass). WB write to $0 -> $0 still reads 0.
- stall=1 for one cycle while beq is in IF/ID -> ID/EX controls all 0 that cycle, IF/ID holds beq, branch=1 appears the following cycle. stall=1 and flush=1 together -> IF/ID becomes NOP.
- Opcode 0x3F -> illegal_op=1 and all controls 0. reset pulsed low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
